uart_byte_fifo: RTL

//  Synchronous byte FIFO placed between the UART receiver (single-cycle valid pulse, no backpressure)
//  and the UART transmitter (valid/ready). It absorbs bursts while TX is busy, so back-to-back RX

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 27 ++
 rtl/uart_byte_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: baud timing for the 12 MHz iCE board and FIFO defaults.
// Also provides the FIFO depth helper used by the byte FIFO and its storage array.
package uart_pkg;

  localparam int UART_PERIOD     = 104;  // 12 MHz / 115200 baud
  localparam int UART_PERIOD_TH  = 52;   // mid-bit sample point
  localparam int FIFO_WIDTH      = 8;
  localparam int FIFO_DEPTH_LOG2 = 4;

  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte FIFO storage: one synchronous write port, asynchronous read for show-ahead output.
// Contents are deliberately not reset so the array can map onto logic or SB_RAM.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);

  localparam int DEPTH = fifo_depth(DEPTH_LOG2);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_byte_fifo.sv
// Byte FIFO between the UART receiver (strobe, no backpressure) and transmitter (valid/ready).
// Tracks occupancy and counts bytes lost when a strobe arrives while full and nothing drains.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH      = FIFO_WIDTH,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
  parameter int DROP_W     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  output logic [DROP_W-1:0]     drop_count,
  input  logic                  clr_stats
);

  localparam int                 DEPTH     = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [DROP_W-1:0]     r_drop_count;

  logic w_pop;
  logic w_push;
  logic w_drop;

  assign out_valid = (r_count != '0);
  assign full      = (r_count == DEPTH_CNT);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte while draining.
  assign w_pop  = out_valid & out_ready;
  assign w_push = in_valid & (~full | w_pop);
  assign w_drop = in_valid & full & ~w_pop;

  uart_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .CLK     (CLK),
    .i_we    (w_push & ~RST),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (out_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear wins over a coincident drop so software never sees a stale count after clearing.
  always_ff @(posedge CLK) begin
    if (RST || clr_stats) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= sat_inc(r_drop_count);
    end
  end

  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
